// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the Tetris board logic.
// Holds the board geometry, the empty-cell colour, the lock/clear state
// encoding and small helpers that turn (row, col) into a cell index and a
// cell index into a bit offset inside the packed board vector.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELLS   = BOARD_W * BOARD_H;

  // CELLS as an 8-bit value so index range checks compare equal widths
  localparam logic [7:0] CELL_LIMIT = 8'(CELLS);

  localparam logic [2:0] COLOR_EMPTY = 3'd0;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  // Cell index for a row/column pair; row 0 is the top of the playfield
  function automatic logic [7:0] cell_index(input logic [4:0] row, input logic [3:0] col);
    return 8'(row) * 8'(BOARD_W) + 8'(col);
  endfunction

  // Each cell is 3 bits wide in the packed board, so the offset needs 10 bits
  function automatic logic [9:0] bit_base(input logic [7:0] idx);
    return 10'(idx) * 10'd3;
  endfunction

endpackage

// File: rtl/board_row_full.sv
// Row-full detector.
// Reduces one row of BOARD_W 3-bit colours to a single flag that is high
// only when every cell of the row is occupied.
// Ports:
//   row_cells  in   BOARD_W*3  colours of one row, column 0 in the low bits
//   full       out  1          1 when no cell of the row is empty
module board_row_full
  import tetris_pkg::*;
(
  input  logic [BOARD_W*3-1:0] row_cells,
  output logic                 full
);

  // Any empty column knocks the flag down
  always_comb begin
    full = 1'b1;
    for (int c = 0; c < BOARD_W; c++) begin
      if (row_cells[c*3 +: 3] == COLOR_EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/board_lock_clear.sv
// Playfield store with piece locking and line clearing.
// Holds the BOARD_W x BOARD_H colour grid, answers collision queries for a
// candidate piece, writes a locked piece into the grid, then walks the rows
// bottom-up removing full rows by shifting everything above down one row.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clear                wipe board and game_over (only acted on in IDLE)
//   lock_req             lock the piece on blk_1..blk_4 with blk_color
//   blk_1..blk_4         cell indices of the piece to lock
//   blk_color            piece colour (0 means empty)
//   q_blk_1..q_blk_4     candidate cell indices for the collision query
//   collide              registered collision answer for q_blk_*
//   rd_addr / rd_color   registered render read port
//   busy                 high whenever the lock/clear engine is not idle
//   lock_done            one-cycle pulse when a lock has fully settled
//   lines_cleared        rows removed by the most recent lock
//   game_over            sticky flag: a lock landed on an occupied cell
module board_lock_clear
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       lock_req,
  input  logic [7:0] blk_1,
  input  logic [7:0] blk_2,
  input  logic [7:0] blk_3,
  input  logic [7:0] blk_4,
  input  logic [2:0] blk_color,
  input  logic [7:0] q_blk_1,
  input  logic [7:0] q_blk_2,
  input  logic [7:0] q_blk_3,
  input  logic [7:0] q_blk_4,
  output logic       collide,
  input  logic [7:0] rd_addr,
  output logic [2:0] rd_color,
  output logic       busy,
  output logic       lock_done,
  output logic [2:0] lines_cleared,
  output logic       game_over
);

  logic [CELLS*3-1:0]   board;
  state_t               state;
  logic [7:0]           lat_blk [4];
  logic [2:0]           lat_color;
  logic [4:0]           scan_row;
  logic [4:0]           shift_row;
  logic [2:0]           line_cnt;
  logic [7:0]           q_idx [4];
  logic [BOARD_W*3-1:0] scan_cells;
  logic                 scan_full;
  logic                 hit_occupied;
  logic                 query_hit;

  assign q_idx[0] = q_blk_1;
  assign q_idx[1] = q_blk_2;
  assign q_idx[2] = q_blk_3;
  assign q_idx[3] = q_blk_4;

  // Gather the row currently under scan so a single row-full detector serves every row
  always_comb begin
    scan_cells = '0;
    for (int c = 0; c < BOARD_W; c++) begin
      scan_cells[c*3 +: 3] = board[bit_base(cell_index(scan_row, 4'(c))) +: 3];
    end
  end

  board_row_full u_row_full (
    .row_cells (scan_cells),
    .full      (scan_full)
  );

  // Detect whether the latched piece lands on anything already on the board;
  // this looks at the board before the write, so duplicate indices never
  // trip it on their own
  always_comb begin
    hit_occupied = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lat_blk[i] < CELL_LIMIT) begin
        if (board[bit_base(lat_blk[i]) +: 3] != COLOR_EMPTY) hit_occupied = 1'b1;
      end
    end
  end

  // Candidate placement collides if any cell is off the board or occupied
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (q_idx[i] >= CELL_LIMIT) begin
        query_hit = 1'b1;
      end else if (board[bit_base(q_idx[i]) +: 3] != COLOR_EMPTY) begin
        query_hit = 1'b1;
      end
    end
  end

  // Lock/clear engine: owns the board contents and all status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      board         <= '0;
      lat_blk[0]    <= 8'd0;
      lat_blk[1]    <= 8'd0;
      lat_blk[2]    <= 8'd0;
      lat_blk[3]    <= 8'd0;
      lat_color     <= COLOR_EMPTY;
      scan_row      <= 5'd0;
      shift_row     <= 5'd0;
      line_cnt      <= 3'd0;
      busy          <= 1'b0;
      lock_done     <= 1'b0;
      lines_cleared <= 3'd0;
      game_over     <= 1'b0;
    end else begin
      lock_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            board     <= '0;
            game_over <= 1'b0;
          end else if (lock_req) begin
            lat_blk[0] <= blk_1;
            lat_blk[1] <= blk_2;
            lat_blk[2] <= blk_3;
            lat_blk[3] <= blk_4;
            lat_color  <= blk_color;
            line_cnt   <= 3'd0;
            busy       <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          for (int i = 0; i < 4; i++) begin
            if (lat_blk[i] < CELL_LIMIT) board[bit_base(lat_blk[i]) +: 3] <= lat_color;
          end
          if (hit_occupied) game_over <= 1'b1;
          scan_row <= 5'(BOARD_H - 1);
          state    <= SCAN;
        end
        SCAN: begin
          if (scan_full) begin
            if (line_cnt != 3'd4) line_cnt <= line_cnt + 3'd1;
            shift_row <= scan_row;
            state     <= SHIFT;
          end else if (scan_row == 5'd0) begin
            state <= DONE;
          end else begin
            scan_row <= scan_row - 5'd1;
          end
        end
        SHIFT: begin
          // Copy one row down per cycle; after the top row is blanked the
          // same scan row is tested again since new contents dropped into it
          if (shift_row != 5'd0) begin
            for (int c = 0; c < BOARD_W; c++) begin
              board[bit_base(cell_index(shift_row, 4'(c))) +: 3] <=
                board[bit_base(cell_index(shift_row - 5'd1, 4'(c))) +: 3];
            end
            shift_row <= shift_row - 5'd1;
          end else begin
            for (int c = 0; c < BOARD_W; c++) begin
              board[bit_base(cell_index(5'd0, 4'(c))) +: 3] <= COLOR_EMPTY;
            end
            state <= SCAN;
          end
        end
        DONE: begin
          lock_done     <= 1'b1;
          lines_cleared <= line_cnt;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Render read port and collision answer, both one edge behind their inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_color <= COLOR_EMPTY;
      collide  <= 1'b0;
    end else begin
      rd_color <= (rd_addr < CELL_LIMIT) ? board[bit_base(rd_addr) +: 3] : COLOR_EMPTY;
      collide  <= query_hit;
    end
  end

endmodule

// File: tb/tb_board_lock_clear.sv
// Self-checking bench for board_lock_clear.
// Keeps a row/column grid model of the playfield and replays every lock
// with the line-removal rules to predict colours, lines cleared, game_over
// and the lock latency, then compares against the DUT.
module tb_board_lock_clear;
  import tetris_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       lock_req;
  logic [7:0] blk_1, blk_2, blk_3, blk_4;
  logic [2:0] blk_color;
  logic [7:0] q_blk_1, q_blk_2, q_blk_3, q_blk_4;
  logic       collide;
  logic [7:0] rd_addr;
  logic [2:0] rd_color;
  logic       busy;
  logic       lock_done;
  logic [2:0] lines_cleared;
  logic       game_over;

  int compareCount  = 0;
  int mismatchCount = 0;

  int grid [BOARD_H][BOARD_W];
  int mdlGameOver;

  board_lock_clear dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .lock_req      (lock_req),
    .blk_1         (blk_1),
    .blk_2         (blk_2),
    .blk_3         (blk_3),
    .blk_4         (blk_4),
    .blk_color     (blk_color),
    .q_blk_1       (q_blk_1),
    .q_blk_2       (q_blk_2),
    .q_blk_3       (q_blk_3),
    .q_blk_4       (q_blk_4),
    .collide       (collide),
    .rd_addr       (rd_addr),
    .rd_color      (rd_color),
    .busy          (busy),
    .lock_done     (lock_done),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelWipe();
    for (int y = 0; y < BOARD_H; y++)
      for (int x = 0; x < BOARD_W; x++)
        grid[y][x] = 0;
    mdlGameOver = 0;
  endfunction

  function automatic int mdlCell(input int idx);
    if (idx < 0 || idx >= CELLS) return 0;
    return grid[idx / BOARD_W][idx % BOARD_W];
  endfunction

  function automatic int mdlCollide(input int q1, input int q2, input int q3, input int q4);
    int q [4];
    q[0] = q1; q[1] = q2; q[2] = q3; q[3] = q4;
    for (int i = 0; i < 4; i++) begin
      if (q[i] >= CELLS) return 1;
      if (mdlCell(q[i]) != 0) return 1;
    end
    return 0;
  endfunction

  // Place the piece, then remove full rows bottom-up; a removed row costs
  // its row number plus two extra cycles on top of the 22-cycle base
  function automatic void modelLock(input int b1, input int b2, input int b3, input int b4,
                                    input int color, output int lines, output int lat);
    int b [4];
    int r;
    int full;
    int finished;
    b[0] = b1; b[1] = b2; b[2] = b3; b[3] = b4;
    for (int i = 0; i < 4; i++)
      if (b[i] < CELLS && mdlCell(b[i]) != 0) mdlGameOver = 1;
    for (int i = 0; i < 4; i++)
      if (b[i] < CELLS) grid[b[i] / BOARD_W][b[i] % BOARD_W] = color;
    lines = 0;
    lat = 22;
    r = BOARD_H - 1;
    finished = 0;
    while (finished == 0) begin
      full = 1;
      for (int x = 0; x < BOARD_W; x++)
        if (grid[r][x] == 0) full = 0;
      if (full == 1) begin
        lines++;
        lat += r + 2;
        for (int y = r; y > 0; y--)
          for (int x = 0; x < BOARD_W; x++)
            grid[y][x] = grid[y-1][x];
        for (int x = 0; x < BOARD_W; x++)
          grid[0][x] = 0;
      end else if (r == 0) begin
        finished = 1;
      end else begin
        r--;
      end
    end
    if (lines > 4) lines = 4;
  endfunction

  task automatic readCell(input int addr, output int color);
    rd_addr = 8'(addr);
    tick();
    color = int'(rd_color);
  endtask

  task automatic queryCollide(input int q1, input int q2, input int q3, input int q4,
                              output int hit);
    q_blk_1 = 8'(q1); q_blk_2 = 8'(q2); q_blk_3 = 8'(q3); q_blk_4 = 8'(q4);
    tick();
    hit = int'(collide);
  endtask

  task automatic checkBoard(input string tag);
    int bad;
    int firstBad;
    int c;
    bad = 0;
    firstBad = -1;
    for (int a = 0; a < 256; a++) begin
      readCell(a, c);
      if (c != mdlCell(a)) begin
        bad++;
        if (firstBad < 0) firstBad = a;
      end
    end
    if (bad != 0) $display("[TB] first differing cell in %s: %0d", tag, firstBad);
    checkOutput({tag, "_bad_cells"}, bad, 0);
  endtask

  task automatic clearBoard();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelWipe();
    checkOutput("game_over_after_clear", int'(game_over), 0);
  endtask

  // Lock one piece, wait for lock_done and check the settled status
  task automatic applyStimulus(input int b1, input int b2, input int b3, input int b4,
                               input int color, output int gotLat, output int gotLines);
    int expLines;
    int expLat;
    int n;
    int got;
    modelLock(b1, b2, b3, b4, color, expLines, expLat);
    blk_1 = 8'(b1); blk_2 = 8'(b2); blk_3 = 8'(b3); blk_4 = 8'(b4);
    blk_color = 3'(color);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    blk_1 = 8'($urandom); blk_2 = 8'($urandom); blk_3 = 8'($urandom); blk_4 = 8'($urandom);
    blk_color = 3'($urandom);
    checkOutput("busy_after_accept", int'(busy), 1);
    n = 0;
    got = 0;
    while (n < 400 && got == 0) begin
      tick();
      n++;
      if (lock_done) got = 1;
    end
    gotLat = n;
    gotLines = int'(lines_cleared);
    if (got == 0) checkOutput("lock_done_timeout", 0, 1);
    else checkOutput("lock_latency", n, expLat);
    checkOutput("lines_cleared", int'(lines_cleared), expLines);
    checkOutput("game_over", int'(game_over), mdlGameOver);
    checkOutput("busy_at_done", int'(busy), 0);
    tick();
    checkOutput("lock_done_width", int'(lock_done), 0);
    checkOutput("lines_held", int'(lines_cleared), expLines);
  endtask

  initial begin
    int lat, lines, c, hit;
    int pulses, doneAt, busyBad, expLat, expLines;
    int cells [4];

    rst_n = 1'b0;
    clear = 1'b0;
    lock_req = 1'b0;
    blk_1 = 8'd0; blk_2 = 8'd0; blk_3 = 8'd0; blk_4 = 8'd0;
    blk_color = 3'd0;
    q_blk_1 = 8'd0; q_blk_2 = 8'd0; q_blk_3 = 8'd0; q_blk_4 = 8'd0;
    rd_addr = 8'd0;
    modelWipe();
    #23;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_lock_done", int'(lock_done), 0);
    checkOutput("reset_lines", int'(lines_cleared), 0);
    checkOutput("reset_game_over", int'(game_over), 0);
    checkOutput("reset_collide", int'(collide), 0);
    checkOutput("reset_rd_color", int'(rd_color), 0);
    tick();

    $display("[TB] directed lock and line clear");
    applyStimulus(190, 191, 192, 193, 7, lat, lines);
    checkOutput("t1_latency", lat, 22);
    checkOutput("t1_lines", lines, 0);
    readCell(191, c); checkOutput("t1_cell191", c, 7);
    readCell(194, c); checkOutput("t1_cell194", c, 0);
    applyStimulus(194, 195, 196, 197, 5, lat, lines);
    checkOutput("t2_latency", lat, 22);
    applyStimulus(188, 189, 198, 199, 5, lat, lines);
    checkOutput("t3_latency", lat, 43);
    checkOutput("t3_lines", lines, 1);
    readCell(198, c); checkOutput("t3_cell198", c, 5);
    readCell(199, c); checkOutput("t3_cell199", c, 5);
    readCell(188, c); checkOutput("t3_cell188", c, 0);
    readCell(190, c); checkOutput("t3_cell190", c, 0);
    readCell(191, c); checkOutput("t3_cell191", c, 0);
    checkBoard("after_line_clear");

    $display("[TB] collision queries");
    queryCollide(0, 1, 2, 200, hit); checkOutput("collide_out_of_range", hit, 1);
    clearBoard();
    queryCollide(0, 1, 2, 3, hit); checkOutput("collide_empty", hit, 0);
    applyStimulus(2, 200, 201, 202, 3, lat, lines);
    queryCollide(0, 1, 2, 3, hit); checkOutput("collide_after_lock", hit, 1);
    queryCollide(255, 10, 11, 12, hit); checkOutput("collide_idx255", hit, 1);

    $display("[TB] game over");
    applyStimulus(190, 191, 192, 193, 1, lat, lines);
    checkOutput("go_before_overlap", int'(game_over), 0);
    applyStimulus(190, 10, 11, 12, 4, lat, lines);
    checkOutput("go_on_overlap", int'(game_over), 1);
    applyStimulus(20, 21, 22, 23, 6, lat, lines);
    checkOutput("go_sticky", int'(game_over), 1);
    clearBoard();
    checkBoard("after_clear");

    $display("[TB] requests while busy are ignored");
    modelLock(100, 101, 102, 103, 2, expLines, expLat);
    blk_1 = 8'd100; blk_2 = 8'd101; blk_3 = 8'd102; blk_4 = 8'd103;
    blk_color = 3'd2;
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    blk_1 = 8'd0; blk_2 = 8'd1; blk_3 = 8'd2; blk_4 = 8'd3;
    blk_color = 3'd7;
    pulses = 0;
    doneAt = -1;
    busyBad = 0;
    for (int n = 1; n <= 60; n++) begin
      lock_req = (n == 2 || n == 5);
      clear = (n == 3);
      tick();
      lock_req = 1'b0;
      clear = 1'b0;
      if (lock_done) begin
        pulses++;
        doneAt = n;
      end
      if (int'(busy) != ((n < expLat) ? 1 : 0)) busyBad++;
    end
    checkOutput("busy_ignore_done_count", pulses, 1);
    checkOutput("busy_ignore_done_at", doneAt, expLat);
    checkOutput("busy_ignore_busy_bad_cycles", busyBad, 0);
    checkBoard("after_ignored_requests");

    $display("[TB] randomized locks");
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) cells[i] = int'($urandom_range(200, 255));
        else cells[i] = int'($urandom_range(12, 19)) * BOARD_W + int'($urandom_range(0, 9));
      end
      applyStimulus(cells[0], cells[1], cells[2], cells[3], int'($urandom_range(1, 7)), lat, lines);
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 4; i++) cells[i] = int'($urandom_range(0, 209));
        queryCollide(cells[0], cells[1], cells[2], cells[3], hit);
        checkOutput("rand_collide", hit, mdlCollide(cells[0], cells[1], cells[2], cells[3]));
      end
      if (it % 10 == 9) checkBoard("rand_board");
      if (it % 12 == 11) clearBoard();
    end

    $display("[TB] reset during line shift");
    clearBoard();
    applyStimulus(0, 1, 2, 3, 1, lat, lines);
    applyStimulus(0, 4, 5, 6, 2, lat, lines);
    applyStimulus(190, 191, 192, 193, 3, lat, lines);
    applyStimulus(194, 195, 196, 197, 4, lat, lines);
    applyStimulus(180, 181, 182, 183, 5, lat, lines);
    applyStimulus(184, 185, 186, 187, 6, lat, lines);
    checkOutput("pre_reset_game_over", int'(game_over), 1);
    blk_1 = 8'd188; blk_2 = 8'd189; blk_3 = 8'd198; blk_4 = 8'd199;
    blk_color = 3'd7;
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    checkOutput("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    checkOutput("midshift_reset_busy", int'(busy), 0);
    checkOutput("midshift_reset_lock_done", int'(lock_done), 0);
    checkOutput("midshift_reset_game_over", int'(game_over), 0);
    checkOutput("midshift_reset_lines", int'(lines_cleared), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    modelWipe();
    tick();
    checkBoard("after_midshift_reset");

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/board_lock_clear.md
Name: board_lock_clear

Overview:
- Playfield store that consumes the four cell indices and colour of the active piece produced by the current-block calculator.
- Answers collision queries for candidate placements.
- On lock, writes the piece into the board, then detects and removes full rows by shifting the rows above down.
- Provides a registered read port for the VGA renderer.

Parameters:
BOARD_W, 10, columns; cell index = row*BOARD_W + col
BOARD_H, 20, rows; row 0 is top
CELLS, BOARD_W*BOARD_H (200), total cells; every index must fit in 8 bits

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous board wipe; honoured only in IDLE
lock_req  in  1  request to lock the piece on blk_1..blk_4
blk_1..blk_4  in  8 each  cell indices of the piece to lock
blk_color  in  3  piece colour; 0 is reserved for empty
q_blk_1..q_blk_4  in  8 each  candidate cell indices for collision query
collide  out  1  registered; 1 if any q_blk index >= CELLS or its cell is nonzero
rd_addr  in  8  render read index
rd_color  out  3  registered colour at rd_addr; 0 if out of range
busy  out  1  high in every state except IDLE
lock_done  out  1  one-cycle pulse in DONE
lines_cleared  out  3  rows removed by the last lock (0..4); held until the next lock
game_over  out  1  sticky; set when a lock writes over an occupied cell; cleared by clear or reset

Behaviour:
- Storage: CELLS x 3-bit registers. Reset value is all 0.
- Reset values of outputs: collide, rd_color, busy, lock_done, lines_cleared and game_over are all 0. The state machine resets to IDLE.
- Reset is asynchronous and acts in any state, including mid-shift. Partial shift results are discarded and the board reads as empty.
- Read port: rd_color is valid on the edge after rd_addr. The read is live in every state, so the renderer may see intermediate shift rows.
- Collision: collide is valid one edge after q_blk_*. It reflects board contents at the sampling edge.
- States and transitions:
  - IDLE: if clear, wipe board and clear game_over. Else if lock_req, latch blk_1..blk_4 and blk_color, zero the line counter, go to WRITE. clear takes priority over lock_req.
  - WRITE: write colour to the 4 latched cells in one cycle. Indices >= CELLS are dropped. Duplicate indices are harmless. If any in-range target was already nonzero, set game_over (the write still occurs). Set row = BOARD_H-1 and go to SCAN.
  - SCAN: test one row per cycle for all cells nonzero.
    - Full: increment the counter, set k = row, go to SHIFT.
    - Not full and row == 0: go to DONE.
    - Otherwise: row = row - 1.
  - SHIFT: one row per cycle.
    - k > 0: row k <= row k-1, then k = k-1.
    - k == 0: row 0 <= all zero, then return to SCAN with the same row, which is re-examined.
  - DONE: lock_done = 1, lines_cleared = counter, go to IDLE.
- lock_req and clear outside IDLE are ignored; no queueing.
- Timing: with no full rows, lock_done is high in the cycle beginning 22 edges after the edge that sampled lock_req. Each cleared row r adds r+2 cycles.
- The counter saturates at 4.

Decomposition:
- Shared package tetris_pkg holds:
  - BOARD_W, BOARD_H, CELLS
  - COLOR_EMPTY = 3'd0
  - state encoding IDLE/WRITE/SCAN/SHIFT/DONE
  - function for index = row*BOARD_W + col
- One sub-module, board_row_full: combinational reduction of one row's BOARD_W colours to a single full flag. It is instantiated once and muxed by the scan row.

Test Plan:
- Reset, then lock 190,191,192,193 with colour 7. Expect:
  - lock_done 22 edges later, lines_cleared = 0
  - rd_addr = 191 gives rd_color = 7 after 1 edge
  - rd_addr = 194 gives 0
- Continuing, lock 194..197 (colour 5), then 188,189,198,199 (colour 5). On the third lock, row 19 fills. Expect:
  - lock_done at 22 + 21 = 43 edges, lines_cleared = 1
  - cells 198 and 199 read 5
  - cells 188, 190 and 191 read 0
- Collision queries:
  - q_blk = {0, 1, 2, 200} gives collide = 1 (out of range)
  - on an empty board, q_blk = {0, 1, 2, 3} gives collide = 0
  - after a lock at cell 2, the same query gives collide = 1
- Lock over an occupied cell 190 → game_over = 1. It holds through further locks, and clear in IDLE drops it to 0 and empties the board.
- Pulse lock_req at cycles 2 and 5 after an accepted lock → ignored. Exactly one lock_done, and busy stays high until it.
- Assert rst_n low during SHIFT of a 2-line clear → busy, lock_done and game_over are 0 immediately, and every rd_addr reads 0.
